// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone-style arbiter issuing one single-cycle slave strobe per transaction.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed M0 > M1 priority.
module wb_arbiter2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_we_i,
    input  logic              m0_stb_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,

    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_we_i,
    input  logic              m1_stb_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,

    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_we_o,
    output logic              s_stb_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,

    output logic              grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_grant;
    logic [AW-1:0]     r_adr;
    logic [DW-1:0]     r_dat;
    logic [DW/8-1:0]   r_sel;
    logic              r_we;
    logic              r_stb;

    logic              w_req_any;
    logic              w_win;
    logic              w_in_wait;

    assign w_req_any = m0_stb_i | m1_stb_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic              r_ptr;

    // Winner selection: on a tie the pointer names the favoured master.
    always_comb begin
        w_win = 1'b0;
        if (m0_stb_i && m1_stb_i) begin
            w_win = r_ptr;
        end else if (m1_stb_i) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
    end
`else
    // Winner selection: M0 always wins a tie.
    always_comb begin
        w_win = 1'b0;
        if (m0_stb_i) begin
            w_win = 1'b0;
        end else if (m1_stb_i) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
    end
`endif

    // Transaction sequencer: latch winner in IDLE, pulse strobe in ISSUE, await ack in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_adr   <= {AW{1'b0}};
            r_dat   <= {DW{1'b0}};
            r_sel   <= {(DW/8){1'b0}};
            r_we    <= 1'b0;
            r_stb   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stb <= 1'b0;
                    if (w_req_any) begin
                        r_adr   <= w_win ? m1_adr_i : m0_adr_i;
                        r_dat   <= w_win ? m1_dat_i : m0_dat_i;
                        r_sel   <= w_win ? m1_sel_i : m0_sel_i;
                        r_we    <= w_win ? m1_we_i  : m0_we_i;
                        r_grant <= w_win;
                        r_stb   <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_stb   <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_stb <= 1'b0;
                    if (s_ack_i) begin
                        r_state <= ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                        r_ptr   <= ~r_grant;
`endif
                    end
                end
                default: begin
                    r_stb   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Acks outside WAIT (including during reset) never reach a master.
    assign w_in_wait = (r_state == ST_WAIT) && !reset;

    // Return path: only the granted master sees ack and read data.
    always_comb begin
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = {DW{1'b0}};
        m1_dat_o = {DW{1'b0}};
        if (w_in_wait && !r_grant) begin
            m0_ack_o = s_ack_i;
            m0_dat_o = s_dat_i;
        end else if (w_in_wait && r_grant) begin
            m1_ack_o = s_ack_i;
            m1_dat_o = s_dat_i;
        end else begin
            m0_ack_o = 1'b0;
            m1_ack_o = 1'b0;
        end
    end

    assign s_adr_o = r_adr;
    assign s_dat_o = r_dat;
    assign s_sel_o = r_sel;
    assign s_we_o  = r_we;
    assign s_stb_o = r_stb;
    assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: memory slave model plus a transaction-level reference
// (shadow memory, grant-order model) with randomized requests from both masters.
module tb_wb_arbiter2;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] m0_adr, m0_dat_w, m0_dat_r, m1_adr, m1_dat_w, m1_dat_r;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_stb, m0_ack, m1_we, m1_stb, m1_ack;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic [3:0]  s_sel;
    logic        s_we, s_stb, s_ack, grant;
    logic        mem_ack, force_ack, init_pulse;
    int          mem_lat;
    int          mem_cnt = 0;
    int          stb_total = 0;
    int          wr_total = 0;
    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];
    int          compared = 0;
    int          mismatched = 0;

    assign s_ack = mem_ack | force_ack;

    wb_arbiter2 #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat_w), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_dat_o(m0_dat_r), .m0_ack_o(m0_ack),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat_w), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_dat_o(m1_dat_r), .m1_ack_o(m1_ack),
        .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_stb_o(s_stb), .s_dat_i(s_dat_r), .s_ack_i(s_ack),
        .grant_o(grant)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    // Memory slave: acks (after mem_lat extra cycles) every cycle it sees strobe.
    always @(posedge clk) begin
        mem_ack <= 1'b0;
        if (init_pulse) begin
            for (int i = 0; i < 16; i++) slv_mem[i] <= init_word(i);
        end
        if (mem_cnt > 0) begin
            mem_cnt <= mem_cnt - 1;
            if (mem_cnt == 1) mem_ack <= 1'b1;
        end
        if (s_stb) begin
            stb_total <= stb_total + 1;
            if (s_we) begin
                slv_mem[s_adr[5:2]] <= merge(slv_mem[s_adr[5:2]], s_dat_w, s_sel);
                wr_total <= wr_total + 1;
            end else begin
                s_dat_r <= slv_mem[s_adr[5:2]];
            end
            if (mem_lat == 0) mem_ack <= 1'b1;
            else mem_cnt <= mem_lat;
        end
    end

    // Per-master current request, and observations captured by do_txn.
    logic [31:0] cur_adr [2];
    logic [31:0] cur_dat [2];
    logic [3:0]  cur_sel [2];
    logic        cur_we  [2];
    bit          model_ptr;
    bit          got;
    int          ack_cyc, stb_cnt, oth_ack;
    logic [31:0] rdat, cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we, cap_grant;

    task automatic drive(input bit m, input bit stb);
        if (m) begin
            m1_adr = cur_adr[1]; m1_dat_w = cur_dat[1]; m1_sel = cur_sel[1]; m1_we = cur_we[1]; m1_stb = stb;
        end else begin
            m0_adr = cur_adr[0]; m0_dat_w = cur_dat[0]; m0_sel = cur_sel[0]; m0_we = cur_we[0]; m0_stb = stb;
        end
    endtask

    task automatic new_req(input bit m);
        cur_adr[m] = 32'h80000000 | (32'($urandom_range(0, 15)) << 2);
        cur_dat[m] = $urandom;
        cur_sel[m] = 4'($urandom_range(1, 15));
        cur_we[m]  = 1'($urandom_range(0, 1));
        drive(m, 1'b1);
    endtask

    // Single-master transaction driver; called at posedge+1, returns at posedge+1 with stb dropped.
    task automatic do_txn(input bit m, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input bit we);
        got = 1'b0; ack_cyc = -1; stb_cnt = 0; oth_ack = 0;
        cur_adr[m] = adr; cur_dat[m] = dat; cur_sel[m] = sel; cur_we[m] = we;
        drive(m, 1'b1);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (s_stb) begin
                stb_cnt++; cap_adr = s_adr; cap_dat = s_dat_w; cap_sel = s_sel; cap_we = s_we; cap_grant = grant;
            end
            if (m ? m0_ack : m1_ack) oth_ack++;
            if (m ? m1_ack : m0_ack) begin
                got = 1'b1; ack_cyc = c; rdat = m ? m1_dat_r : m0_dat_r;
                model_ptr = !m;
            end
            @(posedge clk); #1;
        end
        drive(m, 1'b0);
    endtask

    task automatic test_reset();
        m0_stb = 1'b1; m1_stb = 1'b1;
        @(negedge clk);
        compared++;
        if ({s_stb, s_we, s_adr, s_dat_w, s_sel, grant} !== 71'd0) begin
            mismatched++; $display("FAIL reset_slave_regs: got stb=%b we=%b adr=%h dat=%h sel=%h grant=%b want all 0",
                                   s_stb, s_we, s_adr, s_dat_w, s_sel, grant);
        end
        compared++;
        if ({m0_ack, m1_ack, m0_dat_r, m1_dat_r} !== 66'd0) begin
            mismatched++; $display("FAIL reset_master_out: got ack0=%b ack1=%b dat0=%h dat1=%h want 0",
                                   m0_ack, m1_ack, m0_dat_r, m1_dat_r);
        end
        m0_stb = 1'b0; m1_stb = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_m0_read();
        int s0;
        s0 = stb_total;
        do_txn(1'b0, 32'h80000010, 32'h0, 4'hF, 1'b0);
        compared++;
        if (!got || ack_cyc != 2) begin
            mismatched++; $display("FAIL m0_read_latency: got ack=%0b at cycle %0d want cycle 2", got, ack_cyc);
        end
        compared++;
        if (rdat !== 32'hDEADBEEF) begin mismatched++; $display("FAIL m0_read_data: got %h want deadbeef", rdat); end
        compared++;
        if (stb_cnt != 1 || oth_ack != 0 || cap_grant !== 1'b0 || cap_adr !== 32'h80000010 || cap_we !== 1'b0) begin
            mismatched++; $display("FAIL m0_read_issue: stb_cycles=%0d m1_acks=%0d grant=%b adr=%h we=%b want 1 0 0 80000010 0",
                                   stb_cnt, oth_ack, cap_grant, cap_adr, cap_we);
        end
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (stb_total - s0 != 1) begin mismatched++; $display("FAIL m0_read_strobes: got %0d want 1", stb_total - s0); end
    endtask

    task automatic test_m1_write();
        int w0;
        w0 = wr_total;
        do_txn(1'b1, 32'h80000004, 32'h12345678, 4'b0011, 1'b1);
        ref_mem[1] = merge(ref_mem[1], 32'h12345678, 4'b0011);
        compared++;
        if (!got || ack_cyc != 2 || oth_ack != 0) begin
            mismatched++; $display("FAIL m1_write_ack: got ack=%0b cycle %0d m0_acks=%0d want 1 2 0", got, ack_cyc, oth_ack);
        end
        compared++;
        if (cap_we !== 1'b1 || cap_sel !== 4'b0011 || cap_dat !== 32'h12345678 || cap_grant !== 1'b1 || stb_cnt != 1) begin
            mismatched++; $display("FAIL m1_write_issue: we=%b sel=%b dat=%h grant=%b stb_cycles=%0d want 1 0011 12345678 1 1",
                                   cap_we, cap_sel, cap_dat, cap_grant, stb_cnt);
        end
        @(posedge clk); #1;
        compared++;
        if (wr_total - w0 != 1 || slv_mem[1] !== 32'hC0DE5678 || ref_mem[1] !== 32'hC0DE5678) begin
            mismatched++; $display("FAIL m1_write_mem: writes=%0d word=%h want 1 c0de5678", wr_total - w0, slv_mem[1]);
        end
    endtask

    // Both masters keep requesting until n0 / n1 transactions each have completed.
    task automatic test_contention(input int n0, input int n1);
        int rem[2];
        int done[2];
        int exp_q[$];
        int k, s0, budget;
        bit p, nxt[2];
        rem[0] = n0; rem[1] = n1; done[0] = 0; done[1] = 0; p = model_ptr; k = 0;
        while (rem[0] > 0 || rem[1] > 0) begin
            int w;
            if (rem[0] > 0 && rem[1] > 0) w = RR ? int'(p) : 0;
            else w = (rem[0] > 0) ? 0 : 1;
            exp_q.push_back(w); rem[w]--; p = !w[0];
        end
        s0 = stb_total;
        if (n0 > 0) new_req(1'b0);
        if (n1 > 0) new_req(1'b1);
        budget = 3 * (n0 + n1) + 20;
        for (int c = 0; c < budget && (done[0] < n0 || done[1] < n1); c++) begin
            @(negedge clk);
            nxt[0] = 1'b0; nxt[1] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                if (m[0] ? m1_ack : m0_ack) begin
                    logic [31:0] d;
                    d = m[0] ? m1_dat_r : m0_dat_r;
                    compared++;
                    if (k >= exp_q.size() || exp_q[k] != m || grant !== m[0]) begin
                        mismatched++; $display("FAIL grant_order: ack #%0d from M%0d grant=%b want M%0d", k, m, grant,
                                               (k < exp_q.size()) ? exp_q[k] : -1);
                    end
                    if (!cur_we[m]) begin
                        compared++;
                        if (d !== ref_mem[cur_adr[m][5:2]]) begin
                            mismatched++; $display("FAIL read_data: M%0d adr=%h got %h want %h", m, cur_adr[m], d,
                                                   ref_mem[cur_adr[m][5:2]]);
                        end
                    end else begin
                        ref_mem[cur_adr[m][5:2]] = merge(ref_mem[cur_adr[m][5:2]], cur_dat[m], cur_sel[m]);
                    end
                    k++; done[m]++; nxt[m] = 1'b1; model_ptr = !m[0];
                end
            end
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (nxt[m]) begin
                    if ((m == 0 && done[0] < n0) || (m == 1 && done[1] < n1)) new_req(m[0]);
                    else drive(m[0], 1'b0);
                end
            end
        end
        drive(1'b0, 1'b0); drive(1'b1, 1'b0);
        compared++;
        if (done[0] != n0 || done[1] != n1 || stb_total - s0 != n0 + n1) begin
            mismatched++; $display("FAIL contention_count: done %0d/%0d strobes %0d want %0d/%0d strobes %0d",
                                   done[0], done[1], stb_total - s0, n0, n1, n0 + n1);
        end
    endtask

    task automatic test_back_to_back();
        int acks, last, s0;
        bit spacing_ok;
        acks = 0; last = -1; s0 = stb_total; spacing_ok = 1'b1;
        cur_adr[0] = 32'h80000010; cur_dat[0] = 32'h0; cur_sel[0] = 4'hF; cur_we[0] = 1'b0;
        drive(1'b0, 1'b1);
        for (int c = 0; c < 30 && acks < 3; c++) begin
            @(negedge clk);
            if (m0_ack) begin
                compared++;
                if (m0_dat_r !== ref_mem[cur_adr[0][5:2]]) begin
                    mismatched++; $display("FAIL b2b_data: ack %0d got %h want %h", acks, m0_dat_r, ref_mem[cur_adr[0][5:2]]);
                end
                if (last >= 0 && c - last != 3) spacing_ok = 1'b0;
                last = c; acks++; model_ptr = 1'b1;
                @(posedge clk); #1;
                if (acks < 3) begin cur_adr[0] = 32'h80000000 | (32'(acks) << 2); drive(1'b0, 1'b1); end
                else drive(1'b0, 1'b0);
            end else begin
                @(posedge clk); #1;
            end
        end
        drive(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (acks != 3 || !spacing_ok || stb_total - s0 != 3) begin
            mismatched++; $display("FAIL b2b_count: acks=%0d spacing_ok=%0b strobes=%0d want 3 1 3", acks, spacing_ok, stb_total - s0);
        end
    endtask

    task automatic test_reset_mid();
        mem_lat = 1;
        cur_adr[1] = 32'h80000008; cur_dat[1] = 32'h0; cur_sel[1] = 4'hF; cur_we[1] = 1'b0;
        drive(1'b1, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1; drive(1'b1, 1'b0);
        #1;
        compared++;
        if (s_stb !== 1'b0 || grant !== 1'b0 || m1_ack !== 1'b0 || m1_dat_r !== 32'h0) begin
            mismatched++; $display("FAIL reset_mid: stb=%b grant=%b ack1=%b dat1=%h want 0 0 0 0", s_stb, grant, m1_ack, m1_dat_r);
        end
        @(posedge clk); #1; reset = 1'b0; model_ptr = 1'b0;
        @(negedge clk);
        compared++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            mismatched++; $display("FAIL late_ack: ack0=%b ack1=%b s_ack=%b want 0 0", m0_ack, m1_ack, s_ack);
        end
        mem_lat = 0;
        @(posedge clk); #1;
        do_txn(1'b0, 32'h80000010, 32'h0, 4'hF, 1'b0);
        compared++;
        if (!got || ack_cyc != 2 || rdat !== ref_mem[4] || stb_cnt != 1) begin
            mismatched++; $display("FAIL after_reset_txn: ack=%0b cycle %0d dat=%h strobes=%0d want 1 2 %h 1",
                                   got, ack_cyc, rdat, stb_cnt, ref_mem[4]);
        end
    endtask

    task automatic test_spurious_ack();
        int bad;
        bad = 0;
        force_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || s_stb !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        force_ack = 1'b0;
        compared++;
        if (bad != 0) begin mismatched++; $display("FAIL spurious_ack: %0d cycles with ack/strobe want 0", bad); end
        do_txn(1'b1, 32'h80000004, 32'h0, 4'hF, 1'b0);
        compared++;
        if (!got || ack_cyc != 2 || rdat !== ref_mem[1]) begin
            mismatched++; $display("FAIL spurious_next: ack=%0b cycle %0d dat=%h want 1 2 %h", got, ack_cyc, rdat, ref_mem[1]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int a, b;
            a = $urandom_range(0, 4); b = $urandom_range(0, 4);
            if (a == 0 && b == 0) a = 1;
            test_contention(a, b);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; force_ack = 1'b0; mem_lat = 0; init_pulse = 1'b1; model_ptr = 1'b0;
        m0_adr = 32'h0; m0_dat_w = 32'h0; m0_sel = 4'h0; m0_we = 1'b0; m0_stb = 1'b0;
        m1_adr = 32'h0; m1_dat_w = 32'h0; m1_sel = 4'h0; m1_we = 1'b0; m1_stb = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        @(posedge clk); #1; init_pulse = 1'b0;
        test_reset();
        test_m0_read();
        test_m1_write();
        test_contention(1, 1);
        @(posedge clk); #1;
        test_contention(4, 4);
        @(posedge clk); #1;
        test_back_to_back();
        test_reset_mid();
        test_spurious_ack();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
